// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: 32-bit machine word and 4-bit ALU opcode.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  aluop_t;

  localparam aluop_t ALU_ADD = 4'd0;
  localparam aluop_t ALU_SUB = 4'd1;
  localparam aluop_t ALU_AND = 4'd2;
  localparam aluop_t ALU_OR  = 4'd3;
  localparam aluop_t ALU_XOR = 4'd4;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared ALU port and the response port.
// slave is the arbiter's view; master is the surrounding system's view.
interface alu_arbiter_if;
  import cpu_types_pkg::*;

  logic   req0_valid;
  logic   req0_ready;
  aluop_t req0_aluop;
  word_t  req0_portA;
  word_t  req0_portB;

  logic   req1_valid;
  logic   req1_ready;
  aluop_t req1_aluop;
  word_t  req1_portA;
  word_t  req1_portB;

  aluop_t alu_aluop;
  word_t  alu_portA;
  word_t  alu_portB;
  word_t  alu_outport;
  logic   alu_negative;
  logic   alu_zero;
  logic   alu_overflow;

  logic   rsp_valid;
  logic   rsp_ready;
  logic   rsp_id;
  word_t  rsp_out;
  logic   rsp_negative;
  logic   rsp_zero;
  logic   rsp_overflow;

  modport slave (
    input  req0_valid, req0_aluop, req0_portA, req0_portB,
    input  req1_valid, req1_aluop, req1_portA, req1_portB,
    input  alu_outport, alu_negative, alu_zero, alu_overflow,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_aluop, alu_portA, alu_portB,
    output rsp_valid, rsp_id, rsp_out, rsp_negative, rsp_zero, rsp_overflow
  );

  modport master (
    output req0_valid, req0_aluop, req0_portA, req0_portB,
    output req1_valid, req1_aluop, req1_portA, req1_portB,
    output alu_outport, alu_negative, alu_zero, alu_overflow,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_aluop, alu_portA, alu_portB,
    input  rsp_valid, rsp_id, rsp_out, rsp_negative, rsp_zero, rsp_overflow
  );

endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU: accept, execute, respond.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter
  import cpu_types_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  state_t next_state;

  aluop_t op_aluop;
  word_t  op_a;
  word_t  op_b;
  logic   grant_id;

  word_t  rsp_out_q;
  logic   rsp_neg_q;
  logic   rsp_zero_q;
  logic   rsp_ovf_q;
  logic   rsp_id_q;

  logic   any_valid;
  logic   grant_sel;
  logic   accept;

`ifdef ALU_ARB_RR_EN
  logic   last_grant;
`endif

  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
`ifdef ALU_ARB_RR_EN
    // On a tie, favour whoever was not served last.
    if (bus.req0_valid && bus.req1_valid) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = bus.req1_valid;
    end
`else
    grant_sel = ~bus.req0_valid;
`endif
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC:    next_state = RESP;
      RESP:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // No handshake may complete while reset is held.
    if (rst) begin
      accept = 1'b0;
    end
  end

  assign bus.req0_ready   = accept & ~grant_sel;
  assign bus.req1_ready   = accept &  grant_sel;

  assign bus.alu_aluop    = op_aluop;
  assign bus.alu_portA    = op_a;
  assign bus.alu_portB    = op_b;

  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_out      = rsp_out_q;
  assign bus.rsp_negative = rsp_neg_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_overflow = rsp_ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_aluop   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      grant_id   <= 1'b0;
      rsp_out_q  <= '0;
      rsp_neg_q  <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      if (accept) begin
        op_aluop <= grant_sel ? bus.req1_aluop : bus.req0_aluop;
        op_a     <= grant_sel ? bus.req1_portA : bus.req0_portA;
        op_b     <= grant_sel ? bus.req1_portB : bus.req0_portB;
        grant_id <= grant_sel;
`ifdef ALU_ARB_RR_EN
        last_grant <= grant_sel;
`endif
      end
      if (state == EXEC) begin
        rsp_out_q  <= bus.alu_outport;
        rsp_neg_q  <= bus.alu_negative;
        rsp_zero_q <= bus.alu_zero;
        rsp_ovf_q  <= bus.alu_overflow;
        rsp_id_q   <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed and random ops against a transaction-level model.
// Honours ALU_ARB_RR_EN the same way as the design.
module tb_alu_arbiter;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic rst;

  int testCount = 0;
  int failCount = 0;

  bit     lastGrant;
  logic   v  [2];
  aluop_t op [2];
  word_t  pa [2];
  word_t  pb [2];

  word_t  obsOut;
  logic   obsNeg;
  logic   obsZero;
  logic   obsOvf;
  logic   obsId;
  int     order [4];

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {negative, zero, overflow, result}.
  function automatic logic [34:0] aluRef(input aluop_t o, input word_t a, input word_t b);
    word_t r;
    logic  ovf;
    ovf = 1'b0;
    case (o)
      ALU_ADD: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      default: r = a;
    endcase
    return {r[31], (r == 32'd0), ovf, r};
  endfunction

  always_comb begin
    {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_outport} =
      aluRef(bus.alu_aluop, bus.alu_portA, bus.alu_portB);
  end

  function automatic int modelWinner();
    if (v[0] && v[1]) begin
`ifdef ALU_ARB_RR_EN
      return lastGrant ? 0 : 1;
`else
      return 0;
`endif
    end
    return v[1] ? 1 : 0;
  endfunction

  function automatic aluop_t randOp();
    return aluop_t'($urandom_range(0, 4));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic driveReq();
    bus.req0_valid = v[0];
    bus.req0_aluop = op[0];
    bus.req0_portA = pa[0];
    bus.req0_portB = pb[0];
    bus.req1_valid = v[1];
    bus.req1_aluop = op[1];
    bus.req1_portA = pa[1];
    bus.req1_portB = pb[1];
  endtask

  task automatic randPayload(input int n);
    op[n] = randOp();
    pa[n] = $urandom;
    pb[n] = $urandom;
  endtask

  task automatic checkResp(input int w, input logic [34:0] exp);
    checkOutput("rsp_valid", bus.rsp_valid, 1'b1);
    checkOutput("rsp_id", bus.rsp_id, w[0]);
    checkOutput("rsp_out", bus.rsp_out, exp[31:0]);
    checkOutput("rsp_flags", {bus.rsp_negative, bus.rsp_zero, bus.rsp_overflow}, exp[34:32]);
    checkOutput("resp_readys", {bus.req1_ready, bus.req0_ready}, 2'b00);
  endtask

  // Runs one transaction from an IDLE cycle; holdCycles is the number of RESP cycles with rsp_ready low.
  task automatic applyStimulus(input int holdCycles, input bit keepValid);
    int         w;
    logic [34:0] exp;
    driveReq();
    bus.rsp_ready = (holdCycles == 0);
    @(negedge clk);
    w = modelWinner();
    checkOutput("idle_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("ready0", bus.req0_ready, (w == 0));
    checkOutput("ready1", bus.req1_ready, (w == 1));
    exp = aluRef(op[w], pa[w], pb[w]);
    lastGrant = w[0];
    @(posedge clk); #1;
    if (keepValid) randPayload(w);
    else v[w] = 1'b0;
    driveReq();
    @(negedge clk);
    checkOutput("exec_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("exec_readys", {bus.req1_ready, bus.req0_ready}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    checkResp(w, exp);
    obsOut  = bus.rsp_out;
    obsNeg  = bus.rsp_negative;
    obsZero = bus.rsp_zero;
    obsOvf  = bus.rsp_overflow;
    obsId   = bus.rsp_id;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      if (i == holdCycles - 1) bus.rsp_ready = 1'b1;
      @(negedge clk);
      checkResp(w, exp);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    driveReq();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_readys", {bus.req1_ready, bus.req0_ready}, 2'b00);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    lastGrant = 1'b1;
  endtask

  initial begin
    v[0] = 1'b0; v[1] = 1'b0;
    randPayload(0); randPayload(1);
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    driveReq();

    // Reset state, with requester 0 already asking.
    v[0] = 1'b1;
    doReset();
    v[0] = 1'b0;
    driveReq();
    @(negedge clk);
    checkOutput("reset_rsp_id", bus.rsp_id, 1'b0);
    checkOutput("reset_rsp_out", bus.rsp_out, 32'd0);
    checkOutput("reset_alu_ops", {bus.alu_aluop, bus.alu_portA, bus.alu_portB}, 68'd0);
    @(posedge clk); #1;

    // Single add on requester 0.
    v[0] = 1'b1; op[0] = ALU_ADD; pa[0] = 32'h5; pb[0] = 32'h3;
    applyStimulus(0, 1'b0);
    checkOutput("add_out", obsOut, 32'h8);
    checkOutput("add_id", obsId, 1'b0);
    checkOutput("add_zero", obsZero, 1'b0);

    // Zero result on requester 1.
    v[1] = 1'b1; op[1] = ALU_SUB; pa[1] = 32'h7; pb[1] = 32'h7;
    applyStimulus(0, 1'b0);
    checkOutput("sub_out", obsOut, 32'h0);
    checkOutput("sub_zero", obsZero, 1'b1);
    checkOutput("sub_id", obsId, 1'b1);

    // Signed overflow.
    v[0] = 1'b1; op[0] = ALU_ADD; pa[0] = 32'h7FFF_FFFF; pb[0] = 32'h1;
    applyStimulus(0, 1'b0);
    checkOutput("ovf_flag", obsOvf, 1'b1);
    checkOutput("ovf_neg", obsNeg, 1'b1);

    // Backpressure: five cycles of rsp_ready low.
    v[1] = 1'b1; randPayload(1);
    applyStimulus(5, 1'b0);

    // Contention from reset with both requesters continuously valid.
    v[0] = 1'b1; v[1] = 1'b1; randPayload(0); randPayload(1);
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1'b1);
      order[k] = int'(obsId);
    end
`ifdef ALU_ARB_RR_EN
    checkOutput("rr_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}, 8'b00_01_00_01);
`else
    checkOutput("fixed_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}, 8'b00_00_00_00);
`endif
    v[0] = 1'b0; v[1] = 1'b0;
    driveReq();
    @(posedge clk); #1;

    // Reset while an operation is executing.
    v[0] = 1'b1; randPayload(0);
    driveReq();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("midrst_accept", bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    v[0] = 1'b0;
    driveReq();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_exec_readys", {bus.req1_ready, bus.req0_ready}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    lastGrant = 1'b1;
    @(negedge clk);
    checkOutput("midrst_cleared_ops", {bus.alu_portA, bus.alu_portB}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("midrst_no_rsp", bus.rsp_valid, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    v[0] = 1'b1; randPayload(0);
    applyStimulus(1, 1'b0);

    // Random traffic.
    for (int k = 0; k < 20; k++) begin
      v[0] = 1'($urandom_range(0, 1));
      v[1] = v[0] ? 1'($urandom_range(0, 1)) : 1'b1;
      randPayload(0);
      randPayload(1);
      applyStimulus(int'($urandom_range(0, 2)), 1'b0);
      v[0] = 1'b0; v[1] = 1'b0;
      driveReq();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; word_t (32 b) and aluop_t (4 b) SHALL come from cpu_types_pkg.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 reqN_valid  in  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  out  1  requester N operation accepted this cycle.
REQ-006 reqN_aluop  in  4  requester N aluop_t.
REQ-007 reqN_portA, reqN_portB  in  32  requester N operands.
REQ-008 alu_aluop  out  4  to shared ALU aluop.
REQ-009 alu_portA, alu_portB  out  32  to shared ALU operands.
REQ-010 alu_outport  in  32  ALU result.
REQ-011 alu_negative, alu_zero, alu_overflow  in  1 each  ALU flags.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  consumer takes response.
REQ-014 rsp_id  out  1  requester index owning the response.
REQ-015 rsp_out  out  32  registered ALU result.
REQ-016 rsp_negative, rsp_zero, rsp_overflow  out  1 each  registered flags.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP.
REQ-018 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally in that cycle, capture its aluop/portA/portB into operand registers, record grant id, go to EXEC; else stay IDLE.
REQ-019 reqN_ready SHALL be high only in IDLE, only for the granted requester, and never for both.
REQ-020 alu_aluop/alu_portA/alu_portB SHALL always be driven from the operand registers.
REQ-021 EXEC: capture alu_outport and the three flags into response registers, go to RESP.
REQ-022 RESP: rsp_valid=1 with rsp_id, rsp_out and flags stable; on rsp_ready=1 go to IDLE; else hold all response outputs unchanged.
REQ-023 Latency: accept in cycle T -> rsp_valid first high in T+2; with rsp_ready tied high, one operation per 3 cycles.
REQ-024 Requests arriving outside IDLE SHALL not be accepted; requesters hold valid and payload until ready.
REQ-025 The arbiter SHALL not inspect aluop; all ALU flag semantics pass through unchanged.

Reset
REQ-026 RST=1 at a rising edge SHALL force IDLE, clear operand and response registers to 0, rsp_valid=0, rsp_id=0, and set the last-grant pointer to 1.
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight operation with no response issued.
REQ-028 While RST=1, req0_ready and req1_ready SHALL be 0.

Configuration
REQ-029 Macro ALU_ARB_RR_EN defined: round-robin; on simultaneous valid, grant the requester not granted last; pointer updates on every grant.
REQ-030 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins simultaneous requests; pointer unused.
REQ-031 With a single requester valid, both modes SHALL grant it immediately.

Verification
REQ-032 Single op: req0 ALU_ADD A=0x00000005 B=0x00000003 at T -> req0_ready at T, rsp_valid at T+2, rsp_out=0x00000008, rsp_id=0, zero=0.
REQ-033 Flags: req1 ALU_SUB A=B=0x00000007 -> rsp_out=0, rsp_zero=1, rsp_id=1; ALU_ADD 0x7FFFFFFF+1 -> rsp_overflow=1, rsp_negative=1.
REQ-034 Contention, RR defined: both valid continuously from reset -> grant order 0,1,0,1; RR undefined -> 0,0,0,0 with req1 never ready.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_out held constant, no reqN_ready asserted; rsp_ready=1 -> IDLE next cycle.
REQ-036 Reset mid-op: RST=1 in EXEC -> next cycle IDLE, rsp_valid=0 and never asserts for that op; after release a new req0 op completes normally.
